// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory controller.
// Access-size codes and the controller state enum live here so the
// controller, its byte-lane helper and any bench agree on one definition.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dm_state_e;

endpackage

// File: rtl/dm_ctrl_if.sv
// dm_ctrl_if: request/response bundle between a load/store unit (master)
// and the data-memory controller (slave).
interface dm_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dm_byte_lane.sv
// dm_byte_lane: purely combinational lane logic for one 32-bit memory word.
// Merges store data into the old word (little-endian lanes), extracts and
// extends load data, and flags misaligned or illegal-size accesses.
module dm_byte_lane
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] merged,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sh = {addr_lo, 3'b000};
    assign half_sh = {addr_lo[1], 4'b0000};

    // Lane merge, load extract/extend and alignment check
    always_comb begin
        merged     = old_word;
        load_data  = 32'd0;
        misaligned = 1'b0;
        byte_sel   = old_word[byte_sh +: 8];
        half_sel   = old_word[half_sh +: 16];
        case (size)
            SZ_BYTE: begin
                merged[byte_sh +: 8] = wdata[7:0];
                load_data = {{24{sign & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                misaligned = addr_lo[0];
                merged[half_sh +: 16] = wdata[15:0];
                load_data = {{16{sign & half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                misaligned = (addr_lo != 2'b00);
                merged     = wdata;
                load_data  = old_word;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
        if (misaligned) begin
            merged    = old_word;
            load_data = 32'd0;
        end
    end

endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: single-outstanding data-memory controller with a fixed
// request-to-response latency. After reset the memory is zeroed one word
// per cycle before requests are accepted. The access (store commit and
// load sample) happens on the edge that enters the response cycle.
// Optional: define DM_TRACE_EN to print every committed store.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic     clk,
    input  logic     reset,
    dm_ctrl_if.slave bus
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam bit         LAT1      = (LATENCY == 1);
    localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dm_state_e         state;
    logic [ADDR_W-1:0] clear_idx;
    logic [3:0]        wait_cnt;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              req_we_p0;
    logic [1:0]        req_size_p0;
    logic              req_sign_p0;
    logic [ADDR_W+1:0] req_addr_p0;
    logic [31:0]       req_wdata_p0;

    logic              idle;
    logic              accept;
    logic              do_access;
    logic              cur_we;
    logic [1:0]        cur_size;
    logic              cur_sign;
    logic [ADDR_W+1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       old_word;
    logic [31:0]       merged;
    logic [31:0]       load_data;
    logic              misaligned;
    logic              wr_en;

    assign idle   = (state == ST_IDLE);
    assign accept = idle && bus.req_valid;

    // With LATENCY=1 the access happens on the accept edge itself, so the
    // live request fields are used while idle; otherwise the captured copy.
    assign cur_we    = idle ? bus.req_we                  : req_we_p0;
    assign cur_size  = idle ? bus.req_size                : req_size_p0;
    assign cur_sign  = idle ? bus.req_sign                : req_sign_p0;
    assign cur_addr  = idle ? bus.req_addr[ADDR_W+1:0]    : req_addr_p0;
    assign cur_wdata = idle ? bus.req_wdata               : req_wdata_p0;

    assign do_access = (accept && LAT1) || (state == ST_WAIT && wait_cnt == 4'd0);
    assign word_idx  = cur_addr[ADDR_W+1:2];
    assign old_word  = mem[word_idx];
    assign wr_en     = do_access && cur_we && !misaligned;

    dm_byte_lane u_lane (
        .size       (cur_size),
        .sign       (cur_sign),
        .addr_lo    (cur_addr[1:0]),
        .wdata      (cur_wdata),
        .old_word   (old_word),
        .merged     (merged),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign bus.req_ready  = idle;
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Control FSM: clear sweep, accept, latency countdown, response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_CLEAR;
            clear_idx <= '0;
            wait_cnt  <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clear_idx <= clear_idx + 1'b1;
                    if (&clear_idx) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (LAT1) begin
                            state <= ST_RESP;
                        end else begin
                            wait_cnt <= WAIT_INIT;
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) state <= ST_RESP;
                    else                  wait_cnt <= wait_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
            if (do_access) begin
                err_q   <= misaligned;
                rdata_q <= (cur_we || misaligned) ? 32'd0 : load_data;
            end
        end
    end

    // ---- request capture stage (p0) ----
    always_ff @(posedge clk) begin
        if (accept) begin
            req_we_p0    <= bus.req_we;
            req_size_p0  <= bus.req_size;
            req_sign_p0  <= bus.req_sign;
            req_addr_p0  <= bus.req_addr[ADDR_W+1:0];
            req_wdata_p0 <= bus.req_wdata;
        end
    end

    // Memory array: zero sweep during CLEAR, otherwise committed stores
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) mem[clear_idx] <= 32'd0;
        else if (wr_en)        mem[word_idx]  <= merged;
    end

`ifdef DM_TRACE_EN
    logic [31:0] req_pc_p0;
    logic [31:0] req_addr_full_p0;
    logic [31:0] cur_pc;
    logic [31:0] cur_addr_full;

    assign cur_pc        = idle ? bus.req_pc   : req_pc_p0;
    assign cur_addr_full = idle ? bus.req_addr : req_addr_full_p0;

    // Capture the trace-only fields alongside the request
    always_ff @(posedge clk) begin
        if (accept) begin
            req_pc_p0        <= bus.req_pc;
            req_addr_full_p0 <= bus.req_addr;
        end
    end

    // Print every committed store with its merged word
    always_ff @(posedge clk) begin
        if (wr_en)
            $display("%d@%h: *%h <= %h", $time, cur_pc, {cur_addr_full[31:2], 2'b00}, merged);
    end
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: drives the same request stream into a LATENCY=1 and a
// LATENCY=4 controller and checks both against a byte-array memory model.
module tb_dm_ctrl;
    import dm_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_ctrl_if bus1 ();
    dm_ctrl_if bus4 ();

    dm_ctrl #(.ADDR_W(10), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    dm_ctrl #(.ADDR_W(10), .LATENCY(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk;
        int          exp_cyc;
    } exp_t;

    exp_t        q1[$];
    exp_t        q4[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [7:0]  mm [4096];
    logic [31:0] last1, last4;
    bit          known1, known4;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Reference memory: 4096 bytes, index = addr[11:0] (wraps like ADDR_W=10)
    function automatic void model(input bit we, input logic [1:0] sz, input bit sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int base;
        int nb;
        logic [31:0] v;
        base = int'(a[11:0]);
        er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        rd = 32'd0;
        if (er) return;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (we) begin
            for (int i = 0; i < nb; i++) mm[base + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = v | (32'(mm[base + i]) << (8 * i));
            if (sg && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
            rd = v;
        end
    endfunction

    function automatic void mon(input string tag, input logic rv, input logic [31:0] rd,
                                input logic er, inout exp_t q[$],
                                inout logic [31:0] last, inout bit known);
        exp_t e;
        if (rv) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s unexpected resp_valid: got 1, expected 0", tag);
            end else begin
                e = q.pop_front();
                check({tag, " err"}, 32'(er), 32'(e.err));
                check({tag, " latency"}, 32'(cyc), 32'(e.exp_cyc));
                if (e.chk) check({tag, " rdata"}, rd, e.rdata);
                last  = e.rdata;
                known = e.chk;
            end
        end else if (known) begin
            check({tag, " rdata hold"}, rd, last);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            last1 = 32'd0; known1 = 1'b1; last4 = 32'd0; known4 = 1'b1;
        end else begin
            mon("L1", bus1.resp_valid, bus1.resp_rdata, bus1.resp_err, q1, last1, known1);
            mon("L4", bus4.resp_valid, bus4.resp_rdata, bus4.resp_err, q4, last4, known4);
        end
    end

    task automatic drive(input bit v, input bit we, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
        bus1.req_valid = v;  bus4.req_valid = v;
        bus1.req_we    = we; bus4.req_we    = we;
        bus1.req_size  = sz; bus4.req_size  = sz;
        bus1.req_sign  = sg; bus4.req_sign  = sg;
        bus1.req_addr  = a;  bus4.req_addr  = a;
        bus1.req_wdata = wd; bus4.req_wdata = wd;
        bus1.req_pc    = pc; bus4.req_pc    = pc;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!(bus1.req_ready && bus4.req_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 3000);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL ready timeout: got 0, expected 1");
        end
    endtask

    // Issue one request to both controllers and wait for both responses
    task automatic issue(input bit we, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        logic [31:0] rd;
        logic er;
        bit ok;
        int n;
        wait_ready(ok);
        if (!ok) return;
        model(we, sz, sg, a, wd, rd, er);
        e.rdata = rd; e.err = er; e.chk = !we || er;
        e.exp_cyc = cyc + 1; q1.push_back(e);
        e.exp_cyc = cyc + 4; q4.push_back(e);
        drive(1'b1, we, sz, sg, a, wd, $urandom);
        @(negedge clk);
        drive_idle();
        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0 || q4.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL response timeout: got %0d/%0d pending, expected 0/0", q1.size(), q4.size());
            q1.delete();
            q4.delete();
        end
    endtask

    task automatic do_reset();
        int n = 0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst L1 req_ready", 32'(bus1.req_ready), 32'd0);
        check("rst L4 req_ready", 32'(bus4.req_ready), 32'd0);
        check("rst L1 resp_valid", 32'(bus1.resp_valid), 32'd0);
        check("rst L4 resp_valid", 32'(bus4.resp_valid), 32'd0);
        check("rst L1 resp_rdata", bus1.resp_rdata, 32'd0);
        check("rst L4 resp_rdata", bus4.resp_rdata, 32'd0);
        check("rst L1 resp_err", 32'(bus1.resp_err), 32'd0);
        check("rst L4 resp_err", 32'(bus4.resp_err), 32'd0);
        q1.delete();
        q4.delete();
        for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
        reset = 1'b1;
        while (!bus1.req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready rise cycles", 32'(n), 32'd1024);
        check("L4 ready with L1", 32'(bus4.req_ready), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit ok;
        logic [31:0] a;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        do_reset();

        issue(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h12345678);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0);
        issue(1'b1, SZ_HALF, 1'b0, 32'h22, 32'hFFFF8001);
        issue(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0);
        issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
        issue(1'b1, SZ_WORD, 1'b0, 32'h6, 32'hDEADBEEF);
        issue(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
        issue(1'b1, SZ_WORD, 1'b0, 32'h1004, 32'hCAFEF00D);
        issue(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
        issue(1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        issue(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h000000A5);
        issue(1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0);

        for (int i = 0; i < 250; i++) begin
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end

        // Reset while the LATENCY=4 controller is still waiting
        issue(1'b1, SZ_WORD, 1'b0, 32'h40, 32'hAABBCCDD);
        wait_ready(ok);
        if (ok) begin
            e.rdata = 32'd0; e.err = 1'b0; e.chk = 1'b0; e.exp_cyc = cyc + 1;
            q1.push_back(e);
            drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h11111111, 32'h0);
            @(negedge clk);
            drive_idle();
            #1;
        end
        do_reset();
        issue(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
        issue(1'b1, SZ_HALF, 1'b0, 32'h42, 32'h0000BEEF);
        issue(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, meaning word-index width (depth = 2**ADDR_W 32-bit words).
REQ-002 SHALL provide parameter LATENCY, default 1, meaning edges from request accept to response; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-009 SHALL have port req_sign  input  1  load sign-extends when 1, zero-extends when 0.
REQ-010 SHALL have port req_addr  input  32  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-012 SHALL have port req_pc  input  32  PC of issuing instruction, used for trace only.
REQ-013 SHALL have port resp_valid  output  1  one-cycle response pulse.
REQ-014 SHALL have port resp_rdata  output  32  extended load data.
REQ-015 SHALL have port resp_err  output  1  misaligned or illegal-size request.

Function
REQ-016 SHALL implement states CLEAR, IDLE, WAIT and RESP.
REQ-017 CLEAR SHALL write zero to word clear_idx each cycle, incrementing from 0; after word DEPTH-1 it SHALL go to IDLE.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-019 On accept, the block SHALL register all req_* fields; inputs are don't-care afterwards.
REQ-020 On accept, LATENCY=1 SHALL go to RESP; otherwise the block SHALL load a counter with LATENCY-2 and go to WAIT.
REQ-021 WAIT SHALL decrement the counter and go to RESP on the edge where it is 0.
REQ-022 The memory access (write commit and read sample) SHALL occur on the edge entering RESP.
REQ-023 resp_valid SHALL be 1 for exactly the RESP cycle; the next edge SHALL return to IDLE; there is no back-pressure.
REQ-024 Word index SHALL be addr[ADDR_W+1:2]; higher address bits SHALL be ignored, so addresses wrap.
REQ-025 Byte lanes SHALL be little-endian: a byte uses lane addr[1:0]; a half uses lanes addr[1]*2 and +1.
REQ-026 Stores SHALL modify only their own lanes; other bytes of the word SHALL be preserved.
REQ-027 Loads SHALL extract the addressed lanes and extend them to 32 bits per req_sign; req_sign is ignored for word loads.
REQ-028 Half with addr[0]=1, word with addr[1:0]!=0, or size 3 SHALL set resp_err=1, resp_rdata=0 and perform no write, with normal latency.
REQ-029 resp_rdata and resp_err SHALL hold their values until the next RESP.
REQ-030 A load issued after a completed store to the same word SHALL return the stored data.

Reset
REQ-031 Asserting reset at any time, including mid-WAIT/RESP, SHALL abort the operation with no write if the write has not yet committed.
REQ-032 While reset is asserted: state = CLEAR, clear_idx = 0, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-033 Memory SHALL read as all-zero once CLEAR completes; req_ready first rises DEPTH cycles after reset release.

Configuration
REQ-034 With macro DM_TRACE_EN defined, each committed store SHALL print "%d@%h: *%h <= %h" with $time, the PC, the word-aligned address and the merged 32-bit word.
REQ-035 Without DM_TRACE_EN, no display code SHALL be compiled; function is otherwise identical.

Structure
REQ-036 Package dm_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-037 Sub-module dm_byte_lane SHALL be combinational and SHALL perform store-lane merge, load extract/extend, and the misalignment check.

Verification
REQ-038 Reset, then count cycles: req_ready SHALL rise after exactly 1024 cycles; a word load of 0x0 SHALL return 0.
REQ-039 Word store 0x12345678 @0x10, then byte loads @0x11 signed and @0x13 unsigned: SHALL return 0x00000056 and 0x00000012.
REQ-040 Half store 0xFFFF8001 @0x22, then signed half load @0x22: SHALL return 0xFFFF8001; word load @0x20 SHALL return 0x80010000.
REQ-041 Word store @0x6 SHALL give resp_err=1, rdata=0 and leave memory unchanged; a store @0x1004 with ADDR_W=10 SHALL alias @0x4.
REQ-042 LATENCY=4: SHALL give resp_valid exactly 4 edges after accept; reset pulsed in WAIT SHALL leave no write and restart CLEAR.
